// File: rtl/sqrt_arbiter_if.sv
// Requester and datapath signals of the shared square-root arbiter.
// The arbiter takes the slave view; the surrounding logic takes the master view.
interface sqrt_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] radicand0;
  logic             req1;
  logic [WIDTH-1:0] radicand1;
  logic [1:0]       grant;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             timeout;
  logic             busy;
  logic [WIDTH-1:0] sqrt_radicand;
  logic             sqrt_enable;
  logic [WIDTH-1:0] sqrt_root;
  logic             sqrt_valid;

  modport slave (
    input  req0, radicand0, req1, radicand1, sqrt_root, sqrt_valid,
    output grant, done0, done1, result, timeout, busy, sqrt_radicand, sqrt_enable
  );

  modport master (
    output req0, radicand0, req1, radicand1, sqrt_root, sqrt_valid,
    input  grant, done0, done1, result, timeout, busy, sqrt_radicand, sqrt_enable
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin sharing of one square-root datapath between two requesters,
// with a start pulse, a bounded wait for valid and a one-cycle done per operation.
module sqrt_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  sqrt_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             win;

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      rad_q     <= '0;
      en_q      <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      rad_q     <= rad_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  // Next state and next register values
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    result_d  = result_q;
    timeout_d = 1'b0;
    rad_d     = rad_q;
    en_d      = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // With both asking, the one not served last time wins
          win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          grant_d = win ? 2'b10 : 2'b01;
          rad_d   = win ? bus.radicand1 : bus.radicand0;
          last_d  = win;
          en_d    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (bus.sqrt_valid) begin
          result_d = bus.sqrt_root;
          done0_d  = grant_q[0];
          done1_d  = grant_q[1];
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d  = '0;
          timeout_d = 1'b1;
          done0_d   = grant_q[0];
          done1_d   = grant_q[1];
          state_d   = DONE;
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.grant         = grant_q;
  assign bus.done0         = done0_q;
  assign bus.done1         = done1_q;
  assign bus.result        = result_q;
  assign bus.timeout       = timeout_q;
  assign bus.busy          = busy_q;
  assign bus.sqrt_radicand = rad_q;
  assign bus.sqrt_enable   = en_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter: a behavioural sqrt responder with a
// programmable valid delay, and a done monitor that pops expected results.
module tb_sqrt_arbiter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       to;
  } exp_t;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_miss;
  int   vdelay;
  exp_t sb[$];

  sqrt_arbiter_if #(.WIDTH(WIDTH)) ifc ();

  sqrt_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] isqrt(input logic [7:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return 8'(r);
  endfunction

  function automatic logic [1:0] onehot(input int id);
    return (id == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic exp_t mk(input int id, input logic [7:0] res, input logic to);
    exp_t e;
    e.id = id; e.res = res; e.to = to;
    return e;
  endfunction

  // Datapath model: valid pulses on the vdelay-th WAIT edge (0 = never)
  initial begin
    int         n;
    bit         act;
    logic [7:0] root_hold;
    n = 0; act = 0; root_hold = '0;
    ifc.sqrt_valid = 1'b0;
    ifc.sqrt_root  = 8'hA5;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        act = 0;
        ifc.sqrt_valid = 1'b0;
        ifc.sqrt_root  = 8'hA5;
      end else begin
        if (ifc.sqrt_enable) begin
          act = 1; n = 0;
          root_hold = isqrt(ifc.sqrt_radicand);
        end else if (act) begin
          n++;
        end
        ifc.sqrt_valid = act && (vdelay > 0) && (n == vdelay);
        ifc.sqrt_root  = ifc.sqrt_valid ? root_hold : 8'hA5;
        if (ifc.sqrt_valid) act = 0;
      end
    end
  end

  // Done monitor: pops the scoreboard and checks the completed operation
  initial begin
    bit   prev_done;
    int   en_cnt;
    exp_t e;
    prev_done = 0; en_cnt = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_done = 0; en_cnt = 0;
        continue;
      end
      if (ifc.sqrt_enable) en_cnt++;
      if (prev_done) chk("grant_clear", 32'(ifc.grant), 32'd0);
      if (ifc.done0 || ifc.done1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'({ifc.done1, ifc.done0}), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_vec", 32'({ifc.done1, ifc.done0}), 32'(onehot(e.id)));
          chk("grant_at_done", 32'(ifc.grant), 32'(onehot(e.id)));
          chk("result", 32'(ifc.result), 32'(e.res));
          chk("timeout", 32'(ifc.timeout), 32'(e.to));
          chk("enable_pulses", 32'(en_cnt), 32'd1);
          chk("busy_at_done", 32'(ifc.busy), 32'd1);
        end
        en_cnt = 0;
      end else begin
        chk("stray_timeout", 32'(ifc.timeout), 32'd0);
      end
      prev_done = ifc.done0 || ifc.done1;
    end
  end

  task automatic wait_idle();
    int c = 0;
    while (ifc.busy && c < 50) begin
      @(negedge clock);
      c++;
    end
    if (ifc.busy) chk("idle_wait_expired", 32'(ifc.busy), 32'd0);
  endtask

  task automatic wait_dones(input int n, input int budget, output int cyc);
    int seen = 0;
    cyc = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (ifc.done0 || ifc.done1) seen++;
    end
    if (seen < n) chk("done_wait_expired", 32'(seen), 32'(n));
  endtask

  // One-cycle request in IDLE; returns on the START cycle after checking the grant
  task automatic issue(input int id, input logic [7:0] rad);
    wait_idle();
    if (id == 0) begin ifc.req0 = 1'b1; ifc.radicand0 = rad; end
    else         begin ifc.req1 = 1'b1; ifc.radicand1 = rad; end
    @(negedge clock);
    chk("grant", 32'(ifc.grant), 32'(onehot(id)));
    chk("sqrt_radicand", 32'(ifc.sqrt_radicand), 32'(rad));
    chk("sqrt_enable", 32'(ifc.sqrt_enable), 32'd1);
    if (id == 0) ifc.req0 = 1'b0;
    else         ifc.req1 = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(ifc.grant), 32'd0);
    chk({tag, "_done"}, 32'({ifc.done1, ifc.done0}), 32'd0);
    chk({tag, "_result"}, 32'(ifc.result), 32'd0);
    chk({tag, "_timeout"}, 32'(ifc.timeout), 32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_sqrt_radicand"}, 32'(ifc.sqrt_radicand), 32'd0);
    chk({tag, "_sqrt_enable"}, 32'(ifc.sqrt_enable), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    n_vec = 0; n_miss = 0; vdelay = 1;
    reset = 1'b1;
    ifc.req0 = 1'b0; ifc.radicand0 = '0;
    ifc.req1 = 1'b0; ifc.radicand1 = '0;
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clock);

    // Single request, valid on the second WAIT cycle
    vdelay = 2;
    sb.push_back(mk(0, 8'd12, 1'b0));
    issue(0, 8'd144);
    wait_dones(1, 20, cyc);
    chk("lat_valid2", 32'(cyc), 32'd3);

    // Datapath never answers: abandon after TIMEOUT WAIT cycles
    vdelay = 0;
    sb.push_back(mk(0, 8'd0, 1'b1));
    issue(0, 8'd200);
    wait_dones(1, 40, cyc);
    chk("lat_timeout", 32'(cyc), 32'(TIMEOUT + 1));

    // Normal operation right after a timeout
    vdelay = 1;
    sb.push_back(mk(1, 8'd9, 1'b0));
    issue(1, 8'd81);
    wait_dones(1, 20, cyc);
    chk("lat_valid1", 32'(cyc), 32'd2);

    // Valid coincides with the last WAIT cycle: valid wins
    vdelay = TIMEOUT;
    sb.push_back(mk(0, 8'd7, 1'b0));
    issue(0, 8'd49);
    wait_dones(1, 40, cyc);
    chk("lat_edge", 32'(cyc), 32'(TIMEOUT + 1));

    // Reset asserted in WAIT aborts the operation without a done
    vdelay = 0;
    issue(0, 8'd100);
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clock);
    reset = 1'b0;
    vdelay = 1;
    sb.push_back(mk(1, 8'd8, 1'b0));
    issue(1, 8'd64);
    wait_dones(1, 20, cyc);

    // Both requesting continuously: alternate 0,1,0,1 at one op per 4 cycles
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(0, 8'd4, 1'b0));
      sb.push_back(mk(1, 8'd9, 1'b0));
    end
    ifc.req0 = 1'b1; ifc.radicand0 = 8'd16;
    ifc.req1 = 1'b1; ifc.radicand1 = 8'd81;
    wait_dones(4, 40, cyc);
    ifc.req0 = 1'b0; ifc.req1 = 1'b0;
    chk("alt_cycles", 32'(cyc), 32'd15);

    // req1 pulsed once, req0 raised mid-operation and served next
    sb.push_back(mk(1, 8'd5, 1'b0));
    sb.push_back(mk(0, 8'd6, 1'b0));
    issue(1, 8'd25);
    ifc.req0 = 1'b1; ifc.radicand0 = 8'd36;
    wait_dones(1, 20, cyc);
    @(negedge clock);
    chk("idle_between", 32'(ifc.grant), 32'd0);
    @(negedge clock);
    chk("late_req_grant", 32'(ifc.grant), 32'b01);
    ifc.req0 = 1'b0;
    wait_dones(1, 20, cyc);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one square-root datapath between two independent requesters.
- The datapath interface is radicand[7:0] and enable in, root[7:0] and valid_bit out.
- Arbitrates round-robin, latches the winner's radicand and issues a one-cycle enable pulse to the datapath.
- Waits for valid_bit with a timeout guard, then returns the root to the granted requester with a one-cycle done pulse.
- Sits between the switch/keypress front ends and the sqrt unit in the top level.

Parameters:
- WIDTH, 8, width of radicand and root.
- TIMEOUT, 255, maximum WAIT-state cycles before abandoning an operation; legal range 1..255.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request level
- radicand0  input  WIDTH  requester 0 operand, stable while req0 high
- req1  input  1  requester 1 request level
- radicand1  input  WIDTH  requester 1 operand, stable while req1 high
- grant  output  2  one-hot grant; bit n = requester n owns the datapath
- done0  output  1  one-cycle pulse: requester 0 result valid
- done1  output  1  one-cycle pulse: requester 1 result valid
- result  output  WIDTH  last captured root, or 0 on timeout
- timeout  output  1  one-cycle pulse alongside done when the datapath never asserted valid
- busy  output  1  high in any state other than IDLE
- sqrt_radicand  output  WIDTH  operand driven to the datapath
- sqrt_enable  output  1  one-cycle start pulse to the datapath
- sqrt_root  input  WIDTH  root from the datapath
- sqrt_valid  input  1  valid_bit from the datapath

Behaviour:
- All outputs are registered.
- Reset values: grant=00, done0=done1=0, result=0, timeout=0, busy=0, sqrt_radicand=0, sqrt_enable=0, state=IDLE, wait counter=0, last-served pointer=1 (requester 0 wins first).
- States are IDLE, START, WAIT and DONE.
- IDLE:
  - Sample req0/req1 each edge.
  - If only one is high, grant it. If both are high, grant the requester not equal to last-served.
  - On grant: set grant one-hot, latch the winner's radicand into sqrt_radicand, update last-served, go to START.
  - If no request is high, stay in IDLE.
- START:
  - sqrt_enable=1 for exactly this one cycle.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - sqrt_enable=0. The counter increments every cycle.
  - If sqrt_valid=1 at the edge: capture sqrt_root into result and go to DONE with timeout flag clear.
  - Else, if counter==TIMEOUT-1: result=0, go to DONE with timeout flag set.
  - sqrt_valid wins when it coincides with expiry.
- DONE:
  - done<n>=1 for the granted n, and timeout=1 if flagged, for exactly one cycle.
  - Next state is IDLE. grant clears on entry to IDLE.
- Latency: with sqrt_valid already high, done pulses in the third cycle after the IDLE sampling edge. Minimum issue interval is 4 cycles.
- result holds its value until the next DONE. sqrt_radicand holds until the next grant.
- Requesters may drop req any time after grant; the operation still completes and done still pulses. Requests are not queued: a dropped or unserved req is not remembered.
- A request arriving while busy is ignored until IDLE. Because a lone requester is granted whenever it is the only one high, a requester that holds req continuously is served back-to-back.
- Counter width is 8 bits; it does not wrap, because expiry occurs first.
- Reset asserted mid-operation (any state) forces all reset values immediately. An sqrt_enable pulse in progress is cut short and no done is produced.
- busy is high in START, WAIT and DONE.

Test Plan:
- Reset, then req0=1 with radicand0=8'd144 and sqrt_valid high on the second WAIT cycle with sqrt_root=8'd12 -> grant=01, single sqrt_enable pulse with sqrt_radicand=144, done0 pulse, result=12, timeout=0.
- req0 and req1 high together continuously, radicand0=8'd16, radicand1=8'd81 -> service order 0,1,0,1. Results alternate 4 and 9 with matching done0/done1, and each grant lasts exactly until its done.
- TIMEOUT=16, sqrt_valid held low -> done pulses after 16 WAIT cycles with timeout=1 and result=0. The next request then succeeds normally.
- sqrt_valid rises in the same cycle the counter reaches TIMEOUT-1 with sqrt_root=8'd7 -> result=7, timeout=0.
- Assert reset during WAIT -> all outputs return to reset values asynchronously and no done pulses. After release, req1 alone is granted first (grant=10).
- req1 pulsed for one cycle in IDLE then dropped, while req0 is raised during the operation -> req1's operation completes with done1. req0 is granted on the next IDLE sample.
